seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 188 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Drives a common-anode, 4-digit seven-segment display from the tracker's
//   four 5-bit display codes. The four codes (and the overflow flag) are
//   snapshotted together once per full scan, so a refresh always shows one
//   coherent value. The digits are then time-multiplexed one slot at a time.
//   Each slot starts with a short all-anodes-off gap to suppress ghosting.
//
//   Code map: 0-9 are digits, A-F are hex letters, 5'h1F is an underscore,
//   and 5'h10..5'h1E are blank. The digit-0 decimal point lights when the
//   step count has overflowed (si = 1).
//
// Parameters:
//   REFRESH_DIV  - sys_clk cycles per digit slot (>= 2)
//   BLANK_CYCLES - all-anodes-off cycles at the start of each slot
//                  (< REFRESH_DIV)
//   LZB          - 1 enables leading-zero blanking on digits 3..1
//
// Ports:
//   sys_clk   in   1  system clock
//   reset     in   1  asynchronous, active-high reset
//   bcd3..0   in   5  display codes, bcd3 = leftmost digit
//   si        in   1  overflow flag (digit-0 decimal point)
//   an        out  4  anode enables, active-low, an[0] = rightmost digit
//   seg       out  7  segments, active-low, {g,f,e,d,c,b,a}
//   dp        out  1  decimal point, active-low
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter bit LZB          = 1'b0
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [4:0] bcd3,
  input  logic [4:0] bcd2,
  input  logic [4:0] bcd1,
  input  logic [4:0] bcd0,
  input  logic       si,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]  BLANK_LIM = PW'(BLANK_CYCLES);
  localparam logic [4:0]     CODE_BLANK = 5'h10;
  localparam logic [6:0]     SEG_BLANK  = 7'h7F;

  // Segment pattern for one 5-bit code, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] f_decode(input logic [4:0] code);
    logic [6:0] pattern;
    case (code)
      5'h00:   pattern = 7'h40;
      5'h01:   pattern = 7'h79;
      5'h02:   pattern = 7'h24;
      5'h03:   pattern = 7'h30;
      5'h04:   pattern = 7'h19;
      5'h05:   pattern = 7'h12;
      5'h06:   pattern = 7'h02;
      5'h07:   pattern = 7'h78;
      5'h08:   pattern = 7'h00;
      5'h09:   pattern = 7'h10;
      5'h0A:   pattern = 7'h08;
      5'h0B:   pattern = 7'h03;
      5'h0C:   pattern = 7'h46;
      5'h0D:   pattern = 7'h21;
      5'h0E:   pattern = 7'h06;
      5'h0F:   pattern = 7'h0E;
      5'h1F:   pattern = 7'h77;    // underscore: segment d only
      default: pattern = SEG_BLANK; // 5'h10..5'h1E
    endcase
    return pattern;
  endfunction

  // ---------------------------------------------------------------------------
  // Slot timing: prescaler, slot tick, and scan index
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_prescaler;
  logic [1:0]    r_idx;
  logic          r_primed;
  logic          w_tick;
  logic          w_take_snap;

  assign w_tick = (r_prescaler == PRE_LAST);

  // Snapshot at the end of the digit-3 slot, so the next scan starts coherent.
  // Also snapshot once right after reset, so the first scan shows live data
  // rather than waiting a whole blank scan.
  assign w_take_snap = (w_tick && (r_idx == 2'd3)) || !r_primed;

  // NOTE: Clocked state uses non-blocking assignments so that every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_prescaler <= '0;
      r_idx       <= 2'd0;
      r_primed    <= 1'b0;
    end else begin
      r_prescaler <= w_tick ? '0 : r_prescaler + PW'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      r_primed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot of the four codes and the overflow flag
  // ---------------------------------------------------------------------------
  logic [4:0] r_snap [4];
  logic       r_si_snap;

  // NOTE: The four snapshot entries are reset explicitly. The display must
  // come up blank, and there are only four small registers, so this is not
  // a RAM that can be left uninitialised.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 4; d++) begin
        r_snap[d] <= CODE_BLANK;
      end
      r_si_snap <= 1'b0;
    end else if (w_take_snap) begin
      r_snap[3] <= bcd3;
      r_snap[2] <= bcd2;
      r_snap[1] <= bcd1;
      r_snap[0] <= bcd0;
      r_si_snap <= si;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-output logic
  // ---------------------------------------------------------------------------
  logic [4:0] w_code;
  logic [3:0] w_lz_blank;
  logic [6:0] w_seg_next;
  logic [3:0] w_an_next;
  logic       w_dp_next;

  // NOTE: Every signal written here gets a default before any conditional
  // logic, so no path leaves a value held and no latch is inferred.
  always_comb begin
    w_code     = r_snap[r_idx];
    w_lz_blank = 4'b0000;
    w_seg_next = SEG_BLANK;
    w_an_next  = 4'hF;
    w_dp_next  = 1'b1;

    // Leading-zero blanking only extends through an unbroken run of literal
    // zeros from the left. Any hex, underscore or blank code ends the run.
    // Digit 0 is never blanked, so "0" still shows as a zero.
    if (LZB) begin
      w_lz_blank[3] = (r_snap[3] == 5'h00);
      w_lz_blank[2] = w_lz_blank[3] && (r_snap[2] == 5'h00);
      w_lz_blank[1] = w_lz_blank[2] && (r_snap[1] == 5'h00);
    end

    w_seg_next = w_lz_blank[r_idx] ? SEG_BLANK : f_decode(w_code);

    // The anti-ghosting gap at the start of each slot lets the segment lines
    // settle before the new anode turns on.
    if (r_prescaler >= BLANK_LIM) begin
      w_an_next = ~(4'b0001 << r_idx);
    end

    w_dp_next = ~((r_idx == 2'd0) && r_si_snap);
  end

  // ---------------------------------------------------------------------------
  // Registered outputs: glitch-free pad drive, one cycle behind the scan state
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      an  <= 4'hF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= w_an_next;
      seg <= w_seg_next;
      dp  <= w_dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1.
// Two instances share the inputs: one without and one with leading-zero
// blanking.
//
// The reference model works from the clock-edge count k since reset release.
// Output after edge k shows slot position (k-1) mod 4 and digit
// ((k-1) div 4) mod 4. The snapshot is taken at edge 1 and at every 16th edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int R    = 4;
  localparam int B    = 1;
  localparam int SCAN = 4 * R;

  localparam logic [6:0] DIGIT_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [4:0] bcd3, bcd2, bcd1, bcd0;
  logic       si;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  logic [4:0] m_snap [4];
  logic       m_si;

  always #5 sys_clk = ~sys_clk;

  seg7_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZB(1'b0)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .si(si),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  seg7_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZB(1'b1)) dut_lzb (
    .sys_clk(sys_clk), .reset(reset),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .si(si),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_decode(input logic [4:0] code);
    logic [6:0] r;
    if (code < 5'h10) r = DIGIT_TBL[code[3:0]];
    else if (code == 5'h1F) r = 7'h77;
    else r = 7'h7F;
    return r;
  endfunction

  // Expected segments for digit d from the model snapshot, optional LZB.
  function automatic logic [6:0] ref_seg(input bit lzb, input int d);
    bit all_zero;
    all_zero = (d > 0);
    for (int j = 3; j >= d; j--) begin
      if (m_snap[j] != 5'h00) all_zero = 0;
    end
    return (lzb && all_zero) ? 7'h7F : ref_decode(m_snap[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) m_snap[d] = 5'h10;
    m_si = 1'b0;
    k    = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},      an_a,  4'hF);
    check({tag, "_seg"},     seg_a, 7'h7F);
    check({tag, "_dp"},      dp_a,  1'b1);
    check({tag, "_lzb_an"},  an_b,  4'hF);
    check({tag, "_lzb_seg"}, seg_b, 7'h7F);
    check({tag, "_lzb_dp"},  dp_b,  1'b1);
  endtask

  // One clock edge followed by full comparison of both instances.
  task automatic step();
    int         p, d;
    logic [3:0] e_an;
    logic [6:0] e_seg_a, e_seg_b;
    logic       e_dp;
    @(posedge sys_clk);
    k++;
    p       = (k - 1) % R;
    d       = ((k - 1) / R) % 4;
    e_an    = (p < B) ? 4'hF : ~(4'(1) << d);
    e_seg_a = ref_seg(1'b0, d);
    e_seg_b = ref_seg(1'b1, d);
    e_dp    = !(d == 0 && m_si);
    if (k == 1 || (k % SCAN) == 0) begin
      m_snap[3] = bcd3; m_snap[2] = bcd2; m_snap[1] = bcd1; m_snap[0] = bcd0;
      m_si      = si;
    end
    #1;
    check($sformatf("k%0d_an", k),      an_a,  e_an);
    check($sformatf("k%0d_seg", k),     seg_a, e_seg_a);
    check($sformatf("k%0d_dp", k),      dp_a,  e_dp);
    check($sformatf("k%0d_lzb_an", k),  an_b,  e_an);
    check($sformatf("k%0d_lzb_seg", k), seg_b, e_seg_b);
    check($sformatf("k%0d_lzb_dp", k),  dp_b,  e_dp);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_codes(input logic [4:0] c3, c2, c1, c0, input logic s);
    bcd3 = c3; bcd2 = c2; bcd1 = c1; bcd0 = c0; si = s;
  endtask

  initial begin
    logic [4:0] hex_codes [9];
    hex_codes = '{5'h10, 5'h1E, 5'h1F, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F};

    // 1. Reset held with 1,2,3,4 on the inputs, then release and scan.
    reset = 1'b1;
    set_codes(5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge sys_clk);
    reset = 1'b0;
    model_reset();
    run(3 * SCAN);

    // 2. 0,2,_,5 on both instances (LZB=1 blanks digit 3 only).
    set_codes(5'h00, 5'h02, 5'h1F, 5'h05, 1'b0);
    run(2 * SCAN);

    // 3. 9999 with overflow.
    set_codes(5'h09, 5'h09, 5'h09, 5'h09, 1'b1);
    run(2 * SCAN);

    // 4. bcd0 3 -> 7 in the middle of the digit-1 slot.
    set_codes(5'h00, 5'h00, 5'h00, 5'h03, 1'b0);
    run(SCAN);
    run(R + 1);
    bcd0 = 5'h07;
    run((SCAN - R - 1) + SCAN);

    // 5. Blank, underscore and hex codes on digit 0.
    foreach (hex_codes[c]) begin
      bcd0 = hex_codes[c];
      run(SCAN);
    end

    // Random codes (zero-biased for LZB coverage) changing at random cycles.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        bcd3 = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom);
        bcd2 = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom);
        bcd1 = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom);
        bcd0 = 5'($urandom);
        si   = 1'($urandom);
      end
      step();
    end

    // 6. One-cycle reset in the digit-2 slot, then a fresh scan.
    run((SCAN - (k % SCAN)) % SCAN);
    run(2 * R + 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    set_codes(5'h08, 5'h07, 5'h06, 5'h05, 1'b1);
    @(posedge sys_clk);
    #1;
    check_reset_outputs("reset_edge");
    @(negedge sys_clk);
    reset = 1'b0;
    model_reset();
    run(3 * SCAN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
